// File: rtl/reg_bank_latched.sv
// reg_bank_latched: 32 x DATA_W MIPS register bank with registered A/B operands
// and write-first bypass from the write port into the operand latches.
module reg_bank_latched #(
    parameter int DATA_W = 32,
    parameter logic [DATA_W-1:0] SP_INIT = 227,
    parameter logic [DATA_W-1:0] RA_INIT = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reg_write,
    input  logic [4:0]        write_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic [4:0]        read_addr_a,
    input  logic [4:0]        read_addr_b,
    input  logic              load_ab,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [DATA_W-1:0] raw_a,
    output logic [DATA_W-1:0] raw_b
);
    logic [DATA_W-1:0] regs [32];
    logic              wr;
    logic [DATA_W-1:0] next_a, next_b;

    assign wr = reg_write && write_addr != 5'd0;
    // regs[0] is cleared on reset and never written, so it always reads zero
    assign raw_a = regs[read_addr_a];
    assign raw_b = regs[read_addr_b];

    always_comb begin
        next_a = (wr && write_addr == read_addr_a) ? write_data : raw_a;
        next_b = (wr && write_addr == read_addr_b) ? write_data : raw_b;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++)
                regs[i] <= (i == 29) ? SP_INIT : (i == 31) ? RA_INIT : '0;
        end else if (wr) begin
            regs[write_addr] <= write_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_a <= '0;
            out_b <= '0;
        end else if (load_ab) begin
            out_a <= next_a;
            out_b <= next_b;
        end
    end
endmodule

// File: tb/tb_reg_bank_latched.sv
// tb_reg_bank_latched: directed plan plus randomized traffic, checked against
// an array-based model of the register bank.
module tb_reg_bank_latched;
    logic        clk = 0;
    logic        reset = 0;
    logic        reg_write = 0;
    logic [4:0]  write_addr = 0;
    logic [31:0] write_data = 0;
    logic [4:0]  read_addr_a = 0;
    logic [4:0]  read_addr_b = 0;
    logic        load_ab = 0;
    logic [31:0] out_a, out_b, raw_a, raw_b;

    int checks = 0;
    int errors = 0;
    logic [31:0] m [32];
    logic [31:0] ea, eb;

    reg_bank_latched dut (
        .clk(clk), .reset(reset), .reg_write(reg_write), .write_addr(write_addr),
        .write_data(write_data), .read_addr_a(read_addr_a), .read_addr_b(read_addr_b),
        .load_ab(load_ab), .out_a(out_a), .out_b(out_b), .raw_a(raw_a), .raw_b(raw_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m[i] = 0;
        m[29] = 227;
        ea = 0;
        eb = 0;
    endtask

    task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] ra, input logic [4:0] rb, input logic ld);
        reg_write = w; write_addr = wa; write_data = wd;
        read_addr_a = ra; read_addr_b = rb; load_ab = ld;
    endtask

    task automatic tick();
        logic [31:0] na, nb;
        check("raw_a_pre", raw_a, m[read_addr_a]);
        check("raw_b_pre", raw_b, m[read_addr_b]);
        na = (reg_write && write_addr != 0 && write_addr == read_addr_a) ? write_data : m[read_addr_a];
        nb = (reg_write && write_addr != 0 && write_addr == read_addr_b) ? write_data : m[read_addr_b];
        @(posedge clk);
        if (load_ab) begin
            ea = na;
            eb = nb;
        end
        if (reg_write && write_addr != 0) m[write_addr] = write_data;
        #1;
        check("out_a", out_a, ea);
        check("out_b", out_b, eb);
        check("raw_a", raw_a, m[read_addr_a]);
        check("raw_b", raw_b, m[read_addr_b]);
    endtask

    initial begin
        #1 reset = 1;
        #1;
        check("rst_out_a", out_a, 0);
        check("rst_out_b", out_b, 0);
        #1 reset = 0;
        model_reset();
        drive(0, 0, 0, 29, 31, 0);
        #1;
        check("rst_r29", raw_a, 227);
        check("rst_r31", raw_b, 0);
        read_addr_a = 5;
        #0;
        check("rst_r5", raw_a, 0);

        drive(1, 8, 32'hDEADBEEF, 0, 0, 0); tick();
        drive(0, 0, 0, 8, 0, 1); tick();
        check("basic_out_a", out_a, 32'hDEADBEEF);
        check("basic_raw_a", raw_a, 32'hDEADBEEF);

        drive(1, 0, 32'h12345678, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 1); tick();
        check("r0_raw_a", raw_a, 0);
        check("r0_raw_b", raw_b, 0);
        check("r0_out_a", out_a, 0);
        check("r0_out_b", out_b, 0);
        drive(1, 0, 32'hFFFFFFFF, 0, 0, 1); tick();
        check("r0_bypass_a", out_a, 0);

        drive(1, 31, 32'hAA, 31, 31, 1);
        #0;
        check("byp_raw_before", raw_a, 0);
        tick();
        check("byp_out_a", out_a, 32'hAA);
        check("byp_out_b", out_b, 32'hAA);
        check("byp_raw_after", raw_a, 32'hAA);

        drive(0, 0, 0, 0, 29, 1); tick();
        drive(1, 29, 32'h55, 0, 29, 0); tick();
        check("hold_out_b", out_b, 227);
        check("hold_raw_b", raw_b, 32'h55);

        drive(1, 29, 32'h77, 0, 0, 0); tick();
        drive(1, 3, 32'h99, 29, 3, 1);
        reset = 1;
        @(posedge clk);
        #1 reset = 0;
        model_reset();
        drive(0, 0, 0, 29, 3, 0);
        #1;
        check("mid_r29", raw_a, 227);
        check("mid_r3", raw_b, 0);
        check("mid_out_a", out_a, 0);
        check("mid_out_b", out_b, 0);

        for (int n = 0; n < 300; n++) begin
            logic [4:0] wa, ra, rb;
            wa = 5'($urandom_range(0, 31));
            ra = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            rb = ($urandom_range(0, 3) == 0) ? ra : 5'($urandom_range(0, 31));
            drive(1'($urandom), wa, $urandom, ra, rb, 1'($urandom));
            tick();
        end

        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 32; i++) begin
            read_addr_a = 5'(i);
            read_addr_b = 5'(31 - i);
            #1;
            check("final_a", raw_a, m[i]);
            check("final_b", raw_b, m[31 - i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
